// File: rtl/engine_guard.sv
// rtl/engine_guard.sv - clamp, slew-limit and watchdog guard for the four PPM engine commands
//
// Ports:
//   CLK        single clock
//   RESET      synchronous, active-high
//   ENG13_IN   engine 1 command [9:0], engine 3 command [25:16]
//   ENG24_IN   engine 2 command [9:0], engine 4 command [25:16]
//   WR_STROBE  one-cycle pulse on any CPU write to an engine register
//   ARM        level, 1 = motors permitted
//   ENG13_OUT  guarded engines 1/3, same packing, unused bits 0
//   ENG24_OUT  guarded engines 2/4, same packing, unused bits 0
//   STATUS     [1:0] state (0 DISARMED, 1 RUN, 2 FAILSAFE), [2] wdt_fired
module engine_guard #(
    parameter int TICK_DIV  = 1000,
    parameter int STEP      = 4,
    parameter int MAX_VAL   = 1000,
    parameter int WDT_TICKS = 20000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ENG13_IN,
    input  logic [31:0] ENG24_IN,
    input  logic        WR_STROBE,
    input  logic        ARM,
    output logic [31:0] ENG13_OUT,
    output logic [31:0] ENG24_OUT,
    output logic [31:0] STATUS
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int WW = $clog2(WDT_TICKS + 1);

    localparam logic [PW-1:0]      TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0]      WDT_MAX   = WW'(WDT_TICKS);
    localparam logic [WW-1:0]      WDT_LAST  = WW'(WDT_TICKS - 1);
    localparam logic [9:0]         MAX_V     = 10'(MAX_VAL);
    localparam logic [9:0]         STEP_V    = 10'(STEP);
    localparam logic signed [10:0] STEP_S    = 11'(STEP);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_RUN      = 2'd1,
        ST_FAILSAFE = 2'd2
    } state_t;

    state_t          state;
    logic            wdt_fired;
    logic [WW-1:0]   wdt_cnt;
    logic [PW-1:0]   presc;
    logic            tick;

    // Index 0..3 = engines 1,2,3,4
    logic [3:0][9:0] cur;
    logic [3:0][9:0] tgt;

    // Bits outside the two command fields are deliberately dropped
    logic unused_bits;
    assign unused_bits = ^{ENG13_IN[31:26], ENG13_IN[15:10], ENG24_IN[31:26], ENG24_IN[15:10]};

    function automatic logic [9:0] clamp(input logic [9:0] cmd);
        clamp = (cmd > MAX_V) ? MAX_V : cmd;
    endfunction

    // Move one step toward the target; snap when within STEP so it never overshoots
    function automatic logic [9:0] slew(input logic [9:0] c, input logic [9:0] t);
        logic signed [10:0] diff;
        diff = $signed({1'b0, t}) - $signed({1'b0, c});
        if (diff > STEP_S) begin
            slew = c + STEP_V;
        end else if (diff < -STEP_S) begin
            slew = c - STEP_V;
        end else begin
            slew = t;
        end
    endfunction

    always_comb begin
        tgt    = '0;
        tgt[0] = clamp(ENG13_IN[9:0]);
        tgt[1] = clamp(ENG24_IN[9:0]);
        tgt[2] = clamp(ENG13_IN[25:16]);
        tgt[3] = clamp(ENG24_IN[25:16]);
    end

    assign tick = (presc == TICK_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_DISARMED;
            cur       <= '0;
            wdt_cnt   <= '0;
            wdt_fired <= 1'b0;
        end else begin
            case (state)
                ST_DISARMED: begin
                    cur       <= '0;
                    wdt_cnt   <= '0;
                    wdt_fired <= 1'b0;
                    if (ARM && WR_STROBE) begin
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!ARM) begin
                        state     <= ST_DISARMED;
                        cur       <= '0;
                        wdt_cnt   <= '0;
                        wdt_fired <= 1'b0;
                    end else begin
                        if (tick) begin
                            for (int i = 0; i < 4; i++) begin
                                cur[i] <= slew(cur[i], tgt[i]);
                            end
                        end
                        // A write on the expiry tick wins: the counter clears instead
                        if (WR_STROBE) begin
                            wdt_cnt <= '0;
                        end else if (tick) begin
                            if (wdt_cnt >= WDT_LAST) begin
                                wdt_cnt   <= WDT_MAX;
                                state     <= ST_FAILSAFE;
                                wdt_fired <= 1'b1;
                            end else begin
                                wdt_cnt <= wdt_cnt + 1'b1;
                            end
                        end
                    end
                end

                ST_FAILSAFE: begin
                    if (!ARM) begin
                        state     <= ST_DISARMED;
                        cur       <= '0;
                        wdt_cnt   <= '0;
                        wdt_fired <= 1'b0;
                    end else if (tick) begin
                        for (int i = 0; i < 4; i++) begin
                            cur[i] <= slew(cur[i], 10'd0);
                        end
                    end
                end

                default: begin
                    state <= ST_DISARMED;
                    cur   <= '0;
                end
            endcase
        end
    end

    assign ENG13_OUT = {6'd0, cur[2], 6'd0, cur[0]};
    assign ENG24_OUT = {6'd0, cur[3], 6'd0, cur[1]};
    assign STATUS    = {29'd0, wdt_fired, state};

endmodule

// File: tb/tb_engine_guard.sv
// tb/tb_engine_guard.sv - directed scoreboard bench for engine_guard
module tb_engine_guard;

    localparam int TD = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] ENG13_IN;
    logic [31:0] ENG24_IN;
    logic        WR_STROBE;
    logic        ARM;
    logic [31:0] ENG13_OUT;
    logic [31:0] ENG24_OUT;
    logic [31:0] STATUS;

    engine_guard #(
        .TICK_DIV (TD),
        .STEP     (4),
        .MAX_VAL  (1000),
        .WDT_TICKS(10)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ENG13_IN (ENG13_IN),
        .ENG24_IN (ENG24_IN),
        .WR_STROBE(WR_STROBE),
        .ARM      (ARM),
        .ENG13_OUT(ENG13_OUT),
        .ENG24_OUT(ENG24_OUT),
        .STATUS   (STATUS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   phase = 0;
    bit   keepalive = 1'b0;

    function automatic logic [31:0] pk(input int hi, input int lo);
        logic [9:0] h;
        logic [9:0] l;
        h  = 10'(hi);
        l  = 10'(lo);
        pk = {6'd0, h, 6'd0, l};
    endfunction

    function automatic int imin(input int a, input int b);
        imin = (a < b) ? a : b;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        phase = (phase + 1) % TD;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", obs, 32'hDEAD_BEEF);
        end else begin
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
        end
    endtask

    // Advance through the next prescaler tick edge; strobes only on non-tick cycles
    task automatic next_tick();
        for (int i = 0; i < TD; i++) begin
            WR_STROBE = keepalive && (phase != TD - 1);
            step();
            WR_STROBE = 1'b0;
            if (phase == 0) break;
        end
    endtask

    task automatic to_pre_tick();
        for (int i = 0; i < TD; i++) begin
            if (phase == TD - 1) break;
            step();
        end
    endtask

    task automatic strobe_cycle();
        WR_STROBE = 1'b1;
        step();
        WR_STROBE = 1'b0;
    endtask

    initial begin
        RESET     = 1'b1;
        ARM       = 1'b0;
        WR_STROBE = 1'b0;
        ENG13_IN  = '0;
        ENG24_IN  = '0;
        repeat (2) @(posedge CLK);
        #1;
        phase = 0;
        RESET = 1'b0;
        check("rst_eng13", ENG13_OUT, 32'd0);
        check("rst_eng24", ENG24_OUT, 32'd0);
        check("rst_status", STATUS, 32'd0);

        // 1: arm and ramp engines 1/3 toward 50/100
        ARM      = 1'b1;
        ENG13_IN = 32'h0064_0032;
        strobe_cycle();
        check("t1_status_run", STATUS, 32'd1);
        to_pre_tick();
        check("t1_before_first_tick", ENG13_OUT, 32'd0);
        keepalive = 1'b1;
        for (int k = 1; k <= 25; k++) push("t1_ramp", pk(imin(4 * k, 100), imin(4 * k, 50)));
        for (int k = 1; k <= 25; k++) begin
            next_tick();
            pop_check(ENG13_OUT);
        end
        check("t1_eng24_idle", ENG24_OUT, 32'd0);

        // 2: over-range command clamps at 1000
        ENG13_IN = 32'h0064_03FF;
        for (int k = 1; k <= 240; k++) push("t2_clamp_ramp", pk(100, imin(50 + 4 * k, 1000)));
        for (int k = 1; k <= 240; k++) begin
            next_tick();
            pop_check(ENG13_OUT);
        end

        // 3: settle at 100, starve the watchdog, failsafe ramp ignores strobes
        ENG13_IN = pk(100, 100);
        ENG24_IN = pk(100, 100);
        repeat (225) next_tick();
        check("t3_settled13", ENG13_OUT, pk(100, 100));
        check("t3_settled24", ENG24_OUT, pk(100, 100));
        keepalive = 1'b0;
        strobe_cycle();
        repeat (9) next_tick();
        check("t3_nine_ticks_run", STATUS, 32'd1);
        next_tick();
        check("t3_failsafe_status", STATUS, 32'd6);
        check("t3_failsafe_hold", ENG13_OUT, pk(100, 100));
        keepalive = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            push("t3_down13", pk(100 - 4 * k, 100 - 4 * k));
            push("t3_down24", pk(100 - 4 * k, 100 - 4 * k));
        end
        for (int k = 1; k <= 25; k++) begin
            next_tick();
            pop_check(ENG13_OUT);
            pop_check(ENG24_OUT);
        end
        check("t3_status_after_ramp", STATUS, 32'd6);
        keepalive = 1'b0;

        // 4: strobe every 9 ticks keeps RUN; strobe on the expiry tick also wins
        ARM = 1'b0;
        step();
        check("t4_disarmed", STATUS, 32'd0);
        next_tick();
        ARM = 1'b1;
        strobe_cycle();
        for (int t = 1; t <= 100; t++) begin
            next_tick();
            if (t % 9 == 0) begin
                check("t4_run_9", STATUS, 32'd1);
                strobe_cycle();
            end
        end
        check("t4_run_100", STATUS, 32'd1);
        strobe_cycle();
        repeat (9) next_tick();
        to_pre_tick();
        strobe_cycle();
        check("t4_strobe_on_tick", STATUS, 32'd1);
        repeat (9) next_tick();
        check("t4_cleared_run", STATUS, 32'd1);
        next_tick();
        check("t4_cleared_expire", STATUS, 32'd6);

        // 5: disarm at 500, re-arm needs a strobe, junk bits never propagate
        ARM = 1'b0;
        step();
        ARM = 1'b1;
        strobe_cycle();
        ENG13_IN  = 32'h01F4_01F4;
        ENG24_IN  = 32'hFDF4_FDF4;
        keepalive = 1'b1;
        repeat (125) next_tick();
        keepalive = 1'b0;
        check("t5_at500_13", ENG13_OUT, pk(500, 500));
        check("t5_at500_24", ENG24_OUT, pk(500, 500));
        to_pre_tick();
        ARM = 1'b0;
        step();
        check("t5_disarm13", ENG13_OUT, 32'd0);
        check("t5_disarm24", ENG24_OUT, 32'd0);
        check("t5_disarm_status", STATUS, 32'd0);
        ARM = 1'b1;
        repeat (2) next_tick();
        check("t5_no_strobe_status", STATUS, 32'd0);
        check("t5_no_strobe_out", ENG13_OUT, 32'd0);
        strobe_cycle();
        check("t5_rearm_status", STATUS, 32'd1);
        next_tick();
        check("t5_ramp13", ENG13_OUT, pk(4, 4));
        check("t5_ramp24", ENG24_OUT, pk(4, 4));

        // 6: reset in failsafe at 200
        ENG13_IN  = pk(200, 200);
        ENG24_IN  = pk(200, 200);
        keepalive = 1'b1;
        repeat (49) next_tick();
        keepalive = 1'b0;
        strobe_cycle();
        repeat (10) next_tick();
        check("t6_failsafe", STATUS, 32'd6);
        check("t6_at200", ENG13_OUT, pk(200, 200));
        step();
        RESET = 1'b1;
        step();
        phase = 0;
        RESET = 1'b0;
        check("t6_rst13", ENG13_OUT, 32'd0);
        check("t6_rst24", ENG24_OUT, 32'd0);
        check("t6_rst_status", STATUS, 32'd0);
        strobe_cycle();
        check("t6_rearm", STATUS, 32'd1);
        step();
        step();
        check("t6_no_early_tick", ENG13_OUT, 32'd0);
        step();
        check("t6_first_tick", ENG13_OUT, pk(4, 4));

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
